jtoutrun_obj_cmdq: RTL and testbench

Draw-command queue and scheduler between the Out Run object scanner and the object draw engine. The scanner pushes fully decoded sprite commands; the block buffers them and issues them one at a time to the draw engine with a start/busy handshake. At every `hstart` it enforces the per-line budget by flushing unissued work, and it records an overflow flag for that line.

---
 rtl/jtoutrun_obj_pkg.sv | 33 +++
 rtl/jtoutrun_obj_cmdfifo.sv | 69 ++++++
 rtl/jtoutrun_obj_cmdq.sv | 145 ++++++++++++++
 tb/tb_jtoutrun_obj_cmdq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtoutrun_obj_pkg.sv
// Shared definitions for the Out Run object draw-command path: field widths,
// the 48-bit command layout and the scheduler state encoding.
package jtoutrun_obj_pkg;

  localparam int XPOS_W   = 9;
  localparam int OFFSET_W = 16;
  localparam int BANK_W   = 3;
  localparam int PRIO_W   = 2;
  localparam int PAL_W    = 7;
  localparam int HFLIP_W  = 1;
  localparam int HZOOM_W  = 10;
  localparam int CMD_W    = XPOS_W + OFFSET_W + BANK_W + PRIO_W + PAL_W + HFLIP_W + HZOOM_W;

  // Packed MSB-first, so the word reads {hzoom, hflipb, pal, prio, bank, offset, xpos}
  typedef struct packed {
    logic [HZOOM_W-1:0]  hzoom;
    logic [HFLIP_W-1:0]  hflipb;
    logic [PAL_W-1:0]    pal;
    logic [PRIO_W-1:0]   prio;
    logic [BANK_W-1:0]   bank;
    logic [OFFSET_W-1:0] offset;
    logic [XPOS_W-1:0]   xpos;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_ACK    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

endpackage

// File: rtl/jtoutrun_obj_cmdfifo.sv
// Circular command FIFO with extra-MSB pointers, line flush and occupancy.
// A flush combined with a push leaves the pushed word as the only entry.
module jtoutrun_obj_cmdfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic                     full_o,
  output logic                     full_nxt_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   occ_o,
  output logic [W-1:0]             head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW-1:0] waddr_s;
  logic [W-1:0]  mem_q [DEPTH];

  function automatic logic ptr_full(input logic [AW:0] wr, input logic [AW:0] rd);
    return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    waddr_s = wr_q[AW-1:0];
    if (flush_i) begin
      rd_d    = '0;
      waddr_s = '0;
      wr_d    = push_i ? PTR_ONE : '0;
    end else begin
      wr_d = push_i ? wr_q + PTR_ONE : wr_q;
      rd_d = pop_i  ? rd_q + PTR_ONE : rd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[waddr_s] <= din_i;
    end
  end

  assign full_o     = ptr_full(wr_q, rd_q);
  assign full_nxt_o = ptr_full(wr_d, rd_d);
  assign empty_o    = (wr_q == rd_q);
  assign occ_o      = wr_q - rd_q;
  assign head_o     = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/jtoutrun_obj_cmdq.sv
// Object draw-command queue and issue scheduler with per-line flush at hstart.
// Define JTOUTRUN_OBJ_STATS_EN to build the st_drop / st_maxocc counters.
module jtoutrun_obj_cmdq
  import jtoutrun_obj_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                hstart,
  input  logic                sc_start,
  output logic                sc_busy,
  input  logic [XPOS_W-1:0]   sc_xpos,
  input  logic [OFFSET_W-1:0] sc_offset,
  input  logic [BANK_W-1:0]   sc_bank,
  input  logic [PRIO_W-1:0]   sc_prio,
  input  logic [PAL_W-1:0]    sc_pal,
  input  logic [HFLIP_W-1:0]  sc_hflipb,
  input  logic [HZOOM_W-1:0]  sc_hzoom,
  output logic                dr_start,
  input  logic                dr_busy,
  output logic [XPOS_W-1:0]   dr_xpos,
  output logic [OFFSET_W-1:0] dr_offset,
  output logic [BANK_W-1:0]   dr_bank,
  output logic [PRIO_W-1:0]   dr_prio,
  output logic [PAL_W-1:0]    dr_pal,
  output logic [HFLIP_W-1:0]  dr_hflipb,
  output logic [HZOOM_W-1:0]  dr_hzoom,
  output logic                line_ovf,
  output logic [7:0]          st_drop,
  output logic [4:0]          st_maxocc
);

  localparam int AW = $clog2(DEPTH);

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  cmd_t             sc_cmd_s;
  logic [CMD_W-1:0] head_s;
  logic [AW:0]      occ_s;
  logic             fifo_full_s, fifo_full_nxt_s, fifo_empty_s;
  logic             push_s, pop_s, avail_s;
  logic             dr_start_q, sc_busy_q, line_ovf_q, line_ovf_d;

  assign sc_cmd_s = '{hzoom: sc_hzoom, hflipb: sc_hflipb, pal: sc_pal, prio: sc_prio,
                      bank: sc_bank, offset: sc_offset, xpos: sc_xpos};

  // A flush empties the queue first, so a same-cycle push always lands; a pop frees room when full
  assign pop_s   = (state_q == ST_LAUNCH) && !hstart && !fifo_empty_s;
  assign push_s  = sc_start && (hstart || !fifo_full_s || pop_s);
  assign avail_s = !fifo_empty_s || push_s;

  jtoutrun_obj_cmdfifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (hstart),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .din_i      (sc_cmd_s),
    .full_o     (fifo_full_s),
    .full_nxt_o (fifo_full_nxt_s),
    .empty_o    (fifo_empty_s),
    .occ_o      (occ_s),
    .head_o     (head_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = avail_s ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_ACK;
      ST_ACK:    state_d = ST_DRAIN;
      ST_DRAIN:  state_d = dr_busy ? ST_DRAIN : (avail_s ? ST_LAUNCH : ST_IDLE);
      default:   state_d = ST_IDLE;
    endcase
    // hstart returns to IDLE; a same-cycle push is seen there at once, hence LAUNCH
    state_d    = hstart ? (push_s ? ST_LAUNCH : ST_IDLE) : state_d;
    line_ovf_d = hstart ? ((occ_s != '0) || (state_q != ST_IDLE)) : line_ovf_q;
    cmd_d      = pop_s ? cmd_t'(head_s) : cmd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      dr_start_q <= 1'b0;
      sc_busy_q  <= 1'b0;
      line_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      dr_start_q <= (state_d == ST_ISSUE);
      sc_busy_q  <= fifo_full_nxt_s;
      line_ovf_q <= line_ovf_d;
    end
  end

  assign dr_start  = dr_start_q;
  assign sc_busy   = sc_busy_q;
  assign line_ovf  = line_ovf_q;
  assign dr_xpos   = cmd_q.xpos;
  assign dr_offset = cmd_q.offset;
  assign dr_bank   = cmd_q.bank;
  assign dr_prio   = cmd_q.prio;
  assign dr_pal    = cmd_q.pal;
  assign dr_hflipb = cmd_q.hflipb;
  assign dr_hzoom  = cmd_q.hzoom;

`ifdef JTOUTRUN_OBJ_STATS_EN
  logic       drop_s;
  logic [7:0] drop_q, drop_d;
  logic [4:0] maxocc_q, maxocc_d;
  logic [9:0] drop_sum_s;

  assign drop_s = sc_start && !push_s;

  // Rejected pushes and flushed entries both count as lost work
  always_comb begin
    drop_sum_s = 10'(drop_q) + 10'(drop_s) + (hstart ? 10'(occ_s) : 10'd0);
    drop_d     = (drop_sum_s > 10'd255) ? 8'd255 : drop_sum_s[7:0];
    maxocc_d   = (5'(occ_s) > maxocc_q) ? 5'(occ_s) : maxocc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q   <= 8'd0;
      maxocc_q <= 5'd0;
    end else begin
      drop_q   <= drop_d;
      maxocc_q <= maxocc_d;
    end
  end

  assign st_drop   = drop_q;
  assign st_maxocc = maxocc_q;
`else
  assign st_drop   = 8'd0;
  assign st_maxocc = 5'd0;
`endif

endmodule

// File: tb/tb_jtoutrun_obj_cmdq.sv
// Self-checking bench for jtoutrun_obj_cmdq: queue-order scoreboard, issue timing
// arithmetic and a simple draw-engine model driving dr_busy.
module tb_jtoutrun_obj_cmdq;

  localparam int DEPTH = 4;
`ifdef JTOUTRUN_OBJ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  hzoom;
    logic        hflipb;
    logic [6:0]  pal;
    logic [1:0]  prio;
    logic [2:0]  bank;
    logic [15:0] offset;
    logic [8:0]  xpos;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst, hstart, sc_start, sc_busy, dr_start, dr_busy, line_ovf;
  logic [8:0]  sc_xpos, dr_xpos;
  logic [15:0] sc_offset, dr_offset;
  logic [2:0]  sc_bank, dr_bank;
  logic [1:0]  sc_prio, dr_prio;
  logic [6:0]  sc_pal, dr_pal;
  logic        sc_hflipb, dr_hflipb;
  logic [9:0]  sc_hzoom, dr_hzoom;
  logic [7:0]  st_drop;
  logic [4:0]  st_maxocc;
  cmd_t        dr_cmd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_cnt = 0;
  int busy_len = 2;
  bit rand_busy = 1'b0;
  int exp_drop = 0;
  cmd_t got_q[$];
  int   got_cyc[$];
  int   got_len[$];

  always #5 clk = ~clk;

  assign dr_cmd = {dr_hzoom, dr_hflipb, dr_pal, dr_prio, dr_bank, dr_offset, dr_xpos};

  jtoutrun_obj_cmdq #(.DEPTH(DEPTH)) dut (
    .rst(rst), .clk(clk), .hstart(hstart), .sc_start(sc_start), .sc_busy(sc_busy),
    .sc_xpos(sc_xpos), .sc_offset(sc_offset), .sc_bank(sc_bank), .sc_prio(sc_prio),
    .sc_pal(sc_pal), .sc_hflipb(sc_hflipb), .sc_hzoom(sc_hzoom),
    .dr_start(dr_start), .dr_busy(dr_busy),
    .dr_xpos(dr_xpos), .dr_offset(dr_offset), .dr_bank(dr_bank), .dr_prio(dr_prio),
    .dr_pal(dr_pal), .dr_hflipb(dr_hflipb), .dr_hzoom(dr_hzoom),
    .line_ovf(line_ovf), .st_drop(st_drop), .st_maxocc(st_maxocc)
  );

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.xpos   = 9'($urandom);
    c.offset = 16'($urandom);
    c.bank   = 3'($urandom);
    c.prio   = 2'($urandom);
    c.pal    = 7'($urandom);
    c.hflipb = 1'($urandom);
    c.hzoom  = 10'($urandom);
    return c;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [7:0] want_drop();
    return STATS ? 8'(exp_drop) : 8'd0;
  endfunction

  task automatic drive_cmd(input cmd_t c);
    sc_xpos = c.xpos; sc_offset = c.offset; sc_bank = c.bank; sc_prio = c.prio;
    sc_pal = c.pal; sc_hflipb = c.hflipb; sc_hzoom = c.hzoom;
  endtask

  task automatic clear_obs();
    got_q.delete(); got_cyc.delete(); got_len.delete();
  endtask

  // Advance one cycle; log issued draws and run the draw-engine model (busy for busy_len cycles after a start)
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (dr_start) begin
      got_q.push_back(dr_cmd);
      got_cyc.push_back(cyc);
      got_len.push_back(busy_len);
    end
    dr_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    if (dr_start) begin
      busy_cnt = busy_len;
      if (rand_busy) busy_len = $urandom_range(0, 6);
    end
  endtask

  task automatic push_now(input cmd_t c);
    drive_cmd(c);
    sc_start = 1'b1;
    tick();
    sc_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; hstart = 1'b0; sc_start = 1'b0; dr_busy = 1'b0;
    drive_cmd('0);
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (dr_start !== 1'b0) begin n_fail++; $display("FAIL reset_dr_start: got %0b want 0", dr_start); end
    n_tests++; if (sc_busy !== 1'b0) begin n_fail++; $display("FAIL reset_sc_busy: got %0b want 0", sc_busy); end
    n_tests++; if (line_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_line_ovf: got %0b want 0", line_ovf); end
    n_tests++; if (dr_cmd !== 48'h0) begin n_fail++; $display("FAIL reset_dr_fields: got %h want 0", dr_cmd); end
    n_tests++; if (st_drop !== 8'd0 || st_maxocc !== 5'd0) begin
      n_fail++; $display("FAIL reset_stats: got drop %0d maxocc %0d want 0 0", st_drop, st_maxocc);
    end
    rst = 1'b0;
    exp_drop = 0;
  endtask

  task automatic test_single();
    cmd_t c;
    int n0;
    busy_len = 3; clear_obs();
    c = '0; c.xpos = 9'h055; c.offset = 16'h8123;
    n0 = cyc;
    push_now(c);
    repeat (20) tick();
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d pulses want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_tests++; if (got_cyc[0] != n0 + 2) begin n_fail++; $display("FAIL single_latency: got cycle %0d want %0d", got_cyc[0], n0 + 2); end
      n_tests++; if (got_q[0].xpos !== 9'h055 || got_q[0].offset !== 16'h8123) begin
        n_fail++; $display("FAIL single_fields: got xpos %h offset %h want 055 8123", got_q[0].xpos, got_q[0].offset);
      end
    end
    n_tests++; if (dr_cmd !== c) begin n_fail++; $display("FAIL single_hold: got %h want %h", dr_cmd, c); end
  endtask

  task automatic test_fill();
    cmd_t sent[$];
    cmd_t c;
    int stalls, bad;
    busy_len = 20; clear_obs(); stalls = 0;
    while (sent.size() < 5 && stalls < 50) begin
      c = rand_cmd();
      if (!sc_busy) begin drive_cmd(c); sc_start = 1'b1; sent.push_back(c); end
      else begin sc_start = 1'b0; stalls++; end
      tick();
    end
    sc_start = 1'b0;
    n_tests++; if (sc_busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %0b want 1", sc_busy); end
    n_tests++; if (stalls != 0) begin n_fail++; $display("FAIL fill_stall: got %0d stalls want 0", stalls); end
    repeat (150) tick();
    n_tests++; if (got_q.size() != 5) begin n_fail++; $display("FAIL fill_count: got %0d want 5", got_q.size()); end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < sent.size(); i++) if (got_q[i] !== sent[i]) bad++;
    for (int i = 1; i < got_q.size(); i++) if (got_cyc[i] - got_cyc[i-1] != 23) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL fill_order_spacing: got %0d bad draws want 0", bad); end
    n_tests++; if (st_maxocc !== (STATS ? 5'd4 : 5'd0)) begin
      n_fail++; $display("FAIL fill_maxocc: got %0d want %0d", st_maxocc, STATS ? 4 : 0);
    end
    n_tests++; if (sc_busy !== 1'b0) begin n_fail++; $display("FAIL fill_busy_clear: got %0b want 0", sc_busy); end
  endtask

  task automatic test_drop();
    cmd_t sent[$];
    cmd_t c;
    int bad;
    busy_len = 30; clear_obs();
    for (int i = 0; i < 5; i++) begin c = rand_cmd(); sent.push_back(c); push_now(c); end
    n_tests++; if (sc_busy !== 1'b1) begin n_fail++; $display("FAIL drop_full: got %0b want 1", sc_busy); end
    push_now(rand_cmd());
    exp_drop = sat255(exp_drop + 1);
    n_tests++; if (st_drop !== want_drop()) begin n_fail++; $display("FAIL drop_count: got %0d want %0d", st_drop, want_drop()); end
    repeat (200) tick();
    n_tests++; if (got_q.size() != 5) begin n_fail++; $display("FAIL drop_issued: got %0d want 5", got_q.size()); end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < sent.size(); i++) if (got_q[i] !== sent[i]) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL drop_order: got %0d bad want 0", bad); end
  endtask

  task automatic test_hstart_flush();
    cmd_t c;
    int n0;
    busy_len = 30; clear_obs();
    for (int i = 0; i < 4; i++) push_now(rand_cmd());
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    exp_drop = sat255(exp_drop + 3);
    n_tests++; if (line_ovf !== 1'b1) begin n_fail++; $display("FAIL flush_ovf: got %0b want 1", line_ovf); end
    n_tests++; if (sc_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %0b want 0", sc_busy); end
    n_tests++; if (st_drop !== want_drop()) begin n_fail++; $display("FAIL flush_drop: got %0d want %0d", st_drop, want_drop()); end
    repeat (60) tick();
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL flush_no_issue: got %0d draws want 1", got_q.size()); end
    c = rand_cmd();
    n0 = cyc;
    push_now(c);
    repeat (5) tick();
    n_tests++; if (got_q.size() != 2 || got_cyc[got_cyc.size()-1] != n0 + 2 || got_q[got_q.size()-1] !== c) begin
      n_fail++; $display("FAIL flush_next_push: got %0d draws last cycle %0d want 2 draws at %0d", got_q.size(), got_cyc[got_cyc.size()-1], n0 + 2);
    end
    repeat (45) tick();
  endtask

  task automatic test_hstart_push();
    cmd_t c;
    int n0;
    busy_len = 2; clear_obs();
    c = rand_cmd();
    drive_cmd(c);
    hstart = 1'b1; sc_start = 1'b1;
    n0 = cyc;
    tick();
    hstart = 1'b0; sc_start = 1'b0;
    n_tests++; if (line_ovf !== 1'b0) begin n_fail++; $display("FAIL hpush_ovf: got %0b want 0", line_ovf); end
    repeat (10) tick();
    n_tests++; if (got_q.size() != 1 || got_cyc[0] != n0 + 2 || got_q[0] !== c) begin
      n_fail++; $display("FAIL hpush_issue: got %0d draws first at %0d want 1 draw at %0d", got_q.size(), got_cyc[0], n0 + 2);
    end
    n_tests++; if (st_drop !== want_drop()) begin n_fail++; $display("FAIL hpush_drop: got %0d want %0d", st_drop, want_drop()); end
  endtask

  task automatic test_random();
    cmd_t sent[$];
    cmd_t c;
    int guard, bad, lo;
    rand_busy = 1'b1; busy_len = 3; clear_obs(); guard = 0;
    while (sent.size() < 40 && guard < 3000) begin
      if (!sc_busy && $urandom_range(0, 1) == 1) begin
        c = rand_cmd(); drive_cmd(c); sc_start = 1'b1; sent.push_back(c);
      end else begin
        sc_start = 1'b0;
      end
      tick();
      guard++;
    end
    sc_start = 1'b0;
    repeat (300) tick();
    rand_busy = 1'b0;
    n_tests++; if (got_q.size() != 40 || sent.size() != 40) begin
      n_fail++; $display("FAIL rand_count: got %0d issued of %0d pushed want 40", got_q.size(), sent.size());
    end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < sent.size(); i++) if (got_q[i] !== sent[i]) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand_order: got %0d bad want 0", bad); end
    bad = 0;
    for (int i = 1; i < got_q.size(); i++) begin
      lo = (got_len[i-1] + 3 > 4) ? got_len[i-1] + 3 : 4;
      if (got_cyc[i] - got_cyc[i-1] < lo) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand_spacing: got %0d short gaps want 0", bad); end
    n_tests++; if (st_drop !== want_drop()) begin n_fail++; $display("FAIL rand_drop: got %0d want %0d", st_drop, want_drop()); end
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    busy_len = 30; clear_obs();
    push_now(rand_cmd());
    push_now(rand_cmd());
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    exp_drop = sat255(exp_drop + 1);
    n_tests++; if (line_ovf !== 1'b1) begin n_fail++; $display("FAIL mid_ovf_set: got %0b want 1", line_ovf); end
    for (int i = 0; i < 3; i++) begin c = rand_cmd(); c.xpos[0] = 1'b1; push_now(c); end
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    n_tests++; if (dr_start !== 1'b0 || sc_busy !== 1'b0 || line_ovf !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_ctrl: got start %0b busy %0b ovf %0b want 0 0 0", dr_start, sc_busy, line_ovf);
    end
    n_tests++; if (dr_cmd !== 48'h0) begin n_fail++; $display("FAIL mid_reset_fields: got %h want 0", dr_cmd); end
    n_tests++; if (st_drop !== 8'd0 || st_maxocc !== 5'd0) begin
      n_fail++; $display("FAIL mid_reset_stats: got drop %0d maxocc %0d want 0 0", st_drop, st_maxocc);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_drop = 0;
    n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL mid_pre_draws: got %0d want 2", got_q.size()); end
    repeat (60) tick();
    n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL mid_no_issue: got %0d draws want 2", got_q.size()); end
  endtask

  initial begin
    rst = 1'b1; hstart = 1'b0; sc_start = 1'b0; dr_busy = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_drop();
    test_hstart_flush();
    test_hstart_push();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

endmodule
